// File: rtl/tpu_pkg.sv
// Shared constants and the per-lane delay rule for the systolic-edge skew/deskew banks.
package tpu_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int SKEW_MODE     = 0;
  localparam int DESKEW_MODE   = 1;

  // Number of register stages on lane k of an n-lane bank.
  function automatic int skew_depth(input int k, input int n, input int reverse);
    return (reverse != SKEW_MODE) ? (n - k) : (k + 1);
  endfunction

endpackage

// File: rtl/skew_reg_bank_if.sv
// Lane-vector bus of the skew register bank: control and input words in, delayed words out.
interface skew_reg_bank_if
  import tpu_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_CH = 4
);
  logic                    en;
  logic                    clear;
  logic [NUM_CH-1:0]       valid_in;
  logic [NUM_CH*WIDTH-1:0] d;
  logic [NUM_CH-1:0]       valid_out;
  logic [NUM_CH*WIDTH-1:0] q;

  modport master (output en, output clear, output valid_in, output d,
                  input valid_out, input q);
  modport slave  (input en, input clear, input valid_in, input d,
                  output valid_out, output q);
endinterface

// File: rtl/dff_w.sv
// WIDTH-bit register with async active-low reset, synchronous clear and load enable.
module dff_w
  import tpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // clear wins over en so a flush never lets a new word slip in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skew_reg_bank.sv
// Triangular per-lane delay bank (skew when REVERSE=0, deskew when REVERSE=1).
// Optional macro SKEW_ZERO_INVALID_EN zeroes q on lanes whose valid_out is low.
module skew_reg_bank
  import tpu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_CH  = 4,
  parameter int REVERSE = SKEW_MODE
) (
  input logic           clk,
  input logic           reset,
  skew_reg_bank_if.slave bus
);

  logic [NUM_CH-1:0][WIDTH-1:0] qLanes;
  logic [NUM_CH-1:0]            validLanes;

  for (genvar k = 0; k < NUM_CH; k++) begin : gLane
    localparam int DEPTH = skew_depth(k, NUM_CH, REVERSE);

    logic [WIDTH-1:0] dataStage [DEPTH];
    logic [DEPTH-1:0] validStage;

    // Each stage loads its predecessor; stage 0 loads the lane's input word.
    for (genvar s = 0; s < DEPTH; s++) begin : gStage
      logic [WIDTH-1:0] dataPrev;
      logic             validPrev;

      if (s == 0) begin : gHead
        assign dataPrev  = bus.d[k*WIDTH +: WIDTH];
        assign validPrev = bus.valid_in[k];
      end else begin : gBody
        assign dataPrev  = dataStage[s-1];
        assign validPrev = validStage[s-1];
      end

      dff_w #(.WIDTH(WIDTH)) uData (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .clear (bus.clear),
        .d     (dataPrev),
        .q     (dataStage[s])
      );

      dff_w #(.WIDTH(1)) uValid (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .clear (bus.clear),
        .d     (validPrev),
        .q     (validStage[s])
      );
    end

    assign validLanes[k] = validStage[DEPTH-1];
`ifdef SKEW_ZERO_INVALID_EN
    assign qLanes[k] = validStage[DEPTH-1] ? dataStage[DEPTH-1] : '0;
`else
    assign qLanes[k] = dataStage[DEPTH-1];
`endif
  end

  assign bus.q         = qLanes;
  assign bus.valid_out = validLanes;

endmodule
